// File: rtl/pipe_pkg.sv
// Shared definitions for the 4-stage 8-bit pipeline: opcodes, special encodings, control states.
package pipe_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_MUL = 2'b01;
  localparam logic [1:0] OP_JMP = 2'b10;
  localparam logic [1:0] OP_SYS = 2'b11;

  localparam logic [7:0] INS_NOP  = 8'hC0;
  localparam logic [7:0] INS_HALT = 8'hFF;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MUL_WAIT = 2'd1,
    HALT     = 2'd2
  } state_e;

endpackage

// File: rtl/ins_decode.sv
// Combinational instruction field decode, shared by hazard control and the datapath.
module ins_decode
  import pipe_pkg::*;
(
  input  logic [7:0] ins,
  output logic [1:0] opcode,
  output logic [2:0] rd,
  output logic [2:0] rs,
  output logic       reads_regs,
  output logic       is_jmp,
  output logic       is_halt
);

  // Split fields and classify the instruction.
  always_comb begin
    opcode     = ins[7:6];
    rd         = ins[5:3];
    rs         = ins[2:0];
    reads_regs = (opcode == OP_ADD) || (opcode == OP_MUL);
    is_jmp     = (opcode == OP_JMP);
    is_halt    = (ins == INS_HALT);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control: RAW stalls against EX, multi-cycle MUL hold, jump squash and HALT.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MUL_LAT  = 3,
  parameter int unsigned STALL_CW = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          ifid_ins,
  input  logic [2:0]          ex_rd,
  input  logic                ex_we,
  input  logic                ex_is_mul,
  output logic                pc_en,
  output logic                pc_load,
  output logic [5:0]          jmp_addr,
  output logic                ifid_en,
  output logic                ifid_clr,
  output logic                idex_en,
  output logic                idex_clr,
  output logic                halted,
  output logic [STALL_CW-1:0] stall_cnt
);

  localparam int unsigned MCNT_W    = 4;
  localparam bit          MUL_MULTI = (MUL_LAT > 1);

  state_e              state_q, state_d;
  logic [MCNT_W-1:0]   mcnt_q, mcnt_d;
  logic [STALL_CW-1:0] stall_cnt_q, stall_cnt_d;
  logic                stall;

  logic [1:0] opcode;
  logic [2:0] rd, rs;
  logic       reads_regs, is_jmp, is_halt;
  logic       raw_haz;
  logic       unused_opcode;

  ins_decode u_dec (
    .ins        (ifid_ins),
    .opcode     (opcode),
    .rd         (rd),
    .rs         (rs),
    .reads_regs (reads_regs),
    .is_jmp     (is_jmp),
    .is_halt    (is_halt)
  );

  // Opcode is consumed through the decoder's classification flags.
  assign unused_opcode = ^opcode;

  // Only EX can collide with ID because the register file writes through.
  assign raw_haz  = ex_we && reads_regs && ((ex_rd == rd) || (ex_rd == rs));
  assign jmp_addr = ifid_ins[5:0];
  assign stall_cnt = stall_cnt_q;

  // Next-state and strobe decode; reset forces every strobe low.
  always_comb begin
    pc_en    = 1'b1;
    ifid_en  = 1'b1;
    idex_en  = 1'b1;
    pc_load  = 1'b0;
    ifid_clr = 1'b0;
    idex_clr = 1'b0;
    halted   = 1'b0;
    stall    = 1'b0;
    state_d  = state_q;
    mcnt_d   = mcnt_q;

    if (reset) begin
      pc_en   = 1'b0;
      ifid_en = 1'b0;
      idex_en = 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (ex_is_mul && MUL_MULTI) begin
            pc_en   = 1'b0;
            ifid_en = 1'b0;
            idex_en = 1'b0;
            stall   = 1'b1;
            state_d = MUL_WAIT;
            mcnt_d  = MCNT_W'(MUL_LAT - 1);
          end else if (raw_haz) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_clr = 1'b1;
            stall    = 1'b1;
          end else if (is_halt) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_clr = 1'b1;
            state_d  = HALT;
          end else if (is_jmp) begin
            pc_load  = 1'b1;
            ifid_clr = 1'b1;
          end
        end
        MUL_WAIT: begin
          pc_en   = 1'b0;
          ifid_en = 1'b0;
          idex_en = 1'b0;
          stall   = 1'b1;
          mcnt_d  = mcnt_q - MCNT_W'(1);
          if (mcnt_q == MCNT_W'(1)) state_d = RUN;
        end
        HALT: begin
          pc_en    = 1'b0;
          ifid_en  = 1'b0;
          idex_clr = 1'b1;
          halted   = 1'b1;
        end
        default: state_d = RUN;
      endcase
    end

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + STALL_CW'(1);
  end

  // Control state, MUL countdown and saturating stall counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      mcnt_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mcnt_q      <= mcnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed table, corner sequences, random vs reference model.
module tb_pipe_hazard_ctrl;

  localparam int unsigned MUL_LAT  = 3;
  localparam int unsigned STALL_CW = 8;
  localparam int          CNT_MAX  = (1 << STALL_CW) - 1;

  logic                clk = 1'b0;
  logic                reset;
  logic [7:0]          ifid_ins;
  logic [2:0]          ex_rd;
  logic                ex_we;
  logic                ex_is_mul;
  logic                pc_en, pc_load, ifid_en, ifid_clr, idex_en, idex_clr, halted;
  logic [5:0]          jmp_addr;
  logic [STALL_CW-1:0] stall_cnt;

  pipe_hazard_ctrl #(.MUL_LAT(MUL_LAT), .STALL_CW(STALL_CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .ifid_ins  (ifid_ins),
    .ex_rd     (ex_rd),
    .ex_we     (ex_we),
    .ex_is_mul (ex_is_mul),
    .pc_en     (pc_en),
    .pc_load   (pc_load),
    .jmp_addr  (jmp_addr),
    .ifid_en   (ifid_en),
    .ifid_clr  (ifid_clr),
    .idex_en   (idex_en),
    .idex_clr  (idex_clr),
    .halted    (halted),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: remaining MUL hold cycles, halt flag, integer stall count.
  int          m_mul_left = 0;
  bit          m_halted   = 1'b0;
  int          m_cnt      = 0;
  int          n_mul_left;
  bit          n_halted;
  int          n_cnt;
  logic [20:0] m_exp;

  typedef struct {
    logic        r;
    logic [7:0]  ins;
    logic [2:0]  rd;
    logic        we;
    logic        mul;
    logic [20:0] exp;
    string       name;
  } vec_t;

  vec_t tab[16];

  function automatic logic [20:0] pack_exp(input logic pe, input logic ld, input logic [7:0] ins,
                                           input logic ife, input logic ifc, input logic ide,
                                           input logic idc, input logic h, input int sc);
    return {pe, ld, ins[5:0], ife, ifc, ide, idc, h, 8'(sc)};
  endfunction

  function automatic vec_t vec(input logic r, input logic [7:0] ins, input logic [2:0] rd,
                               input logic we, input logic mul,
                               input logic pe, input logic ld, input logic ife, input logic ifc,
                               input logic ide, input logic idc, input logic h, input int sc,
                               input string name);
    vec_t v;
    v.r = r; v.ins = ins; v.rd = rd; v.we = we; v.mul = mul; v.name = name;
    v.exp = pack_exp(pe, ld, ins, ife, ifc, ide, idc, h, sc);
    return v;
  endfunction

  function automatic void model_reset();
    m_mul_left = 0;
    m_halted   = 1'b0;
    m_cnt      = 0;
  endfunction

  // Expected strobes for the current cycle and the model state after the next edge.
  function automatic void model_eval(input logic r, input logic [7:0] ins, input logic [2:0] erd,
                                     input logic we, input logic mul);
    int op, rdf, rsf;
    bit pe, ld, ife, ifc, ide, idc, h, st;
    op  = int'(ins) / 64;
    rdf = (int'(ins) / 8) % 8;
    rsf = int'(ins) % 8;
    pe = 1; ld = 0; ife = 1; ifc = 0; ide = 1; idc = 0; h = 0; st = 0;
    n_mul_left = m_mul_left;
    n_halted   = m_halted;
    if (r) begin
      pe = 0; ife = 0; ide = 0;
      n_mul_left = 0; n_halted = 0;
    end else if (m_halted) begin
      pe = 0; ife = 0; idc = 1; h = 1;
    end else if (m_mul_left > 0) begin
      pe = 0; ife = 0; ide = 0; st = 1;
      n_mul_left = m_mul_left - 1;
    end else if (mul && MUL_LAT > 1) begin
      pe = 0; ife = 0; ide = 0; st = 1;
      n_mul_left = MUL_LAT - 1;
    end else if (we && op < 2 && (int'(erd) == rdf || int'(erd) == rsf)) begin
      pe = 0; ife = 0; idc = 1; st = 1;
    end else if (ins == 8'hFF) begin
      pe = 0; ife = 0; idc = 1;
      n_halted = 1;
    end else if (op == 2) begin
      ld = 1; ifc = 1;
    end
    m_exp = pack_exp(pe, ld, ins, ife, ifc, ide, idc, h, m_cnt);
    if (r) n_cnt = 0;
    else if (st && m_cnt < CNT_MAX) n_cnt = m_cnt + 1;
    else n_cnt = m_cnt;
  endfunction

  function automatic logic [20:0] got_vec();
    return {pc_en, pc_load, jmp_addr, ifid_en, ifid_clr, idex_en, idex_clr, halted, stall_cnt};
  endfunction

  task automatic check(input logic [20:0] exp, input string name);
    logic [20:0] got;
    got = got_vec();
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h {pe,ld,ja,ife,ifc,ide,idc,h,sc}",
               name, $time, got, exp);
    end
  endtask

  // Drive one cycle on the falling edge, check before the rising edge, then advance the model.
  task automatic apply(input logic r, input logic [7:0] ins, input logic [2:0] rd, input logic we,
                       input logic mul, input bit use_tab, input logic [20:0] tab_exp,
                       input string name);
    @(negedge clk);
    reset = r; ifid_ins = ins; ex_rd = rd; ex_we = we; ex_is_mul = mul;
    if (r) model_reset();
    #1;
    model_eval(r, ins, rd, we, mul);
    check(use_tab ? tab_exp : m_exp, name);
    @(posedge clk);
    m_mul_left = n_mul_left;
    m_halted   = n_halted;
    m_cnt      = n_cnt;
  endtask

  initial begin
    reset = 1'b1; ifid_ins = 8'hC0; ex_rd = 3'd0; ex_we = 1'b0; ex_is_mul = 1'b0;

    //            r  ins    rd we mul  pe ld ife ifc ide idc h  sc
    tab[0]  = vec(1, 8'hC0, 0, 0, 0,   0, 0, 0,  0,  0,  0,  0, 0, "reset");
    tab[1]  = vec(0, 8'hC0, 0, 0, 0,   1, 0, 1,  0,  1,  0,  0, 0, "nop");
    tab[2]  = vec(0, 8'h1A, 3, 1, 0,   0, 0, 0,  0,  1,  1,  0, 0, "raw_rd");
    tab[3]  = vec(0, 8'h1A, 3, 0, 0,   1, 0, 1,  0,  1,  0,  0, 1, "raw_clear");
    tab[4]  = vec(0, 8'h95, 0, 0, 0,   1, 1, 1,  1,  1,  0,  0, 1, "jmp");
    tab[5]  = vec(0, 8'h1A, 5, 1, 0,   1, 0, 1,  0,  1,  0,  0, 1, "no_haz");
    tab[6]  = vec(0, 8'h5A, 2, 1, 0,   0, 0, 0,  0,  1,  1,  0, 1, "raw_rs_mul");
    tab[7]  = vec(0, 8'hC0, 0, 0, 1,   0, 0, 0,  0,  0,  0,  0, 2, "mul_start");
    tab[8]  = vec(0, 8'hC0, 0, 0, 0,   0, 0, 0,  0,  0,  0,  0, 3, "mul_wait1");
    tab[9]  = vec(0, 8'hC0, 0, 0, 0,   0, 0, 0,  0,  0,  0,  0, 4, "mul_wait2");
    tab[10] = vec(0, 8'hC0, 0, 0, 0,   1, 0, 1,  0,  1,  0,  0, 5, "mul_done");
    tab[11] = vec(0, 8'hFF, 7, 1, 1,   0, 0, 0,  0,  0,  0,  0, 5, "mul_over_halt");
    tab[12] = vec(0, 8'hFF, 0, 0, 0,   0, 0, 0,  0,  0,  0,  0, 6, "halt_wait1");
    tab[13] = vec(0, 8'hFF, 0, 0, 0,   0, 0, 0,  0,  0,  0,  0, 7, "halt_wait2");
    tab[14] = vec(0, 8'hFF, 0, 0, 0,   0, 0, 0,  0,  1,  1,  0, 8, "halt_enter");
    tab[15] = vec(0, 8'hFF, 0, 0, 0,   0, 0, 0,  0,  1,  1,  1, 8, "halted");

    for (int i = 0; i < 16; i++)
      apply(tab[i].r, tab[i].ins, tab[i].rd, tab[i].we, tab[i].mul, 1'b1, tab[i].exp, tab[i].name);

    // HALT is sticky and the stall count stays frozen whatever arrives.
    for (int i = 0; i < 20; i++)
      apply(1'b0, 8'($urandom), 3'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
            1'b0, '0, "halt_hold");

    // Asynchronous reset in the middle of a MUL hold.
    apply(1'b1, 8'hC0, 0, 0, 0, 1'b0, '0, "rst2");
    apply(1'b0, 8'hC0, 0, 0, 1, 1'b0, '0, "mul2_start");
    apply(1'b0, 8'h1A, 3, 1, 0, 1'b0, '0, "mul2_wait");
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check(pack_exp(0, 0, ifid_ins, 0, 0, 0, 0, 0, 0), "async_rst");
    apply(1'b1, 8'h1A, 3, 1, 0, 1'b0, '0, "rst_hold");
    for (int i = 0; i < 10; i++)
      apply(1'b0, (i % 2 == 0) ? 8'h0B : 8'hC0, 3'($urandom), 1'b0, 1'b0, 1'b0, '0, "post_rst");

    // Saturating counter under a long RAW stall.
    for (int i = 0; i < 300; i++)
      apply(1'b0, 8'h1A, 3, 1, 0, 1'b0, '0, "sat");
    #1;
    n_vec++;
    if (stall_cnt !== 8'hFF) begin
      n_err++;
      $display("FAIL sat_final: got %0d expected 255", stall_cnt);
    end

    // Random traffic against the reference model.
    for (int i = 0; i < 3000; i++)
      apply(1'($urandom_range(0, 63) == 0), 8'($urandom), 3'($urandom), 1'($urandom),
            1'($urandom_range(0, 9) == 0), 1'b0, '0, "rand");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
